// File: rtl/aoc_pkg.sv
// aoc_pkg: shared types, widths and elaboration helpers for the AOC day-3 datapath
package aoc_pkg;
  typedef enum logic {IDLE, DRAIN} drain_state_t;
  localparam int DIGIT_W = 4;
  function automatic bit pow10_fits(input int cap, input int w);
    logic [255:0] p;
    p = 256'(1);
    for (int i = 0; i < cap; i++) p = p * 256'(10);
    return p < (256'(1) << w);
  endfunction
endpackage

// File: rtl/digit_mac.sv
// digit_mac: registered accumulator and decimal place value, loaded to 0/1 and stepped per digit
module digit_mac
  import aoc_pkg::*;
#(
  parameter int SUM_WIDTH = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [DIGIT_W-1:0]   digit,
  output logic [SUM_WIDTH-1:0] acc,
  output logic [SUM_WIDTH-1:0] place
);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      acc   <= '0;
      place <= SUM_WIDTH'(1);
    end else if (load) begin
      acc   <= '0;
      place <= SUM_WIDTH'(1);
    end else if (step) begin
      acc   <= acc + SUM_WIDTH'(digit) * place;
      place <= (place << 3) + (place << 1);
    end
endmodule

// File: rtl/stack_drain.sv
// stack_drain: pops a finished line's digits (LSD first), rebuilds its value and keeps a running total.
// Optional STACK_DRAIN_CHECK_EN adds a sticky err output for bad digits or oversized stacks.
`ifndef DATA_WIDTH
`define DATA_WIDTH 4
`endif
module stack_drain
  import aoc_pkg::*;
#(
  parameter int MAX_CAP   = 4,
  parameter int SUM_WIDTH = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       stack_empty,
  input  logic [`DATA_WIDTH-1:0]     stack_top,
  input  logic [$clog2(MAX_CAP):0]   stack_size,
  output logic                       pop,
  output logic                       busy,
  output logic [SUM_WIDTH-1:0]       line_value,
  output logic                       line_valid,
  output logic [SUM_WIDTH-1:0]       total
`ifdef STACK_DRAIN_CHECK_EN
  ,
  output logic                       err
`endif
);
  if (!pow10_fits(MAX_CAP, SUM_WIDTH)) begin : g_cap_check
    $error("stack_drain: 10**MAX_CAP does not fit in SUM_WIDTH");
  end
  drain_state_t state, state_nx;
  logic load, done;
  logic [DIGIT_W-1:0] digit;
  logic [SUM_WIDTH-1:0] acc, place;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = start ? DRAIN : IDLE;
    else state_nx = stack_empty ? IDLE : DRAIN;
  end
  always_comb begin
    busy = state == DRAIN;
    pop  = busy && !stack_empty;
    load = state == IDLE && start;
    done = busy && stack_empty;
  end
`ifdef STACK_DRAIN_CHECK_EN
  logic bad_digit;
  assign bad_digit = 32'(stack_top) > 9;
  assign digit = bad_digit ? '0 : stack_top[DIGIT_W-1:0];
  always_ff @(posedge clock or posedge reset)
    if (reset) err <= 1'b0;
    else err <= (err && !clear) || (pop && bad_digit) || (load && 32'(stack_size) > MAX_CAP);
`else
  logic unused_ok;
  assign unused_ok = ^{stack_size, stack_top};
  assign digit = stack_top[DIGIT_W-1:0];
`endif
  digit_mac #(.SUM_WIDTH(SUM_WIDTH)) u_mac (
    .clock(clock),
    .reset(reset),
    .load (load),
    .step (pop),
    .digit(digit),
    .acc  (acc),
    .place(place)
  );
  // clear zeroes the old total before a coinciding line is added
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      line_value <= '0;
      line_valid <= 1'b0;
      total      <= '0;
    end else begin
      line_valid <= done;
      if (done) line_value <= acc;
      total <= (clear ? '0 : total) + (done ? acc : '0);
    end
endmodule

// File: tb/tb_stack_drain.sv
// tb_stack_drain: directed scoreboard bench for stack_drain driven by a behavioural stack
`ifndef DATA_WIDTH
`define DATA_WIDTH 4
`endif
module tb_stack_drain;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, clear = 1'b0;
  logic stack_empty, pop, busy, line_valid;
  logic [`DATA_WIDTH-1:0] stack_top;
  logic [2:0] stack_size;
  logic [63:0] line_value, total;
  logic [`DATA_WIDTH-1:0] mem [8];
  int load_cnt = 0, pop_cnt = 0, sp;
  int tests = 0, fails = 0;
  typedef struct {logic [63:0] v; logic [63:0] t;} exp_t;
  exp_t q[$];
`ifdef STACK_DRAIN_CHECK_EN
  logic err;
`endif

  stack_drain #(.MAX_CAP(4), .SUM_WIDTH(64)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .clear(clear),
    .stack_empty(stack_empty),
    .stack_top(stack_top),
    .stack_size(stack_size),
    .pop(pop),
    .busy(busy),
    .line_value(line_value),
    .line_valid(line_valid),
    .total(total)
`ifdef STACK_DRAIN_CHECK_EN
    ,
    .err(err)
`endif
  );

  always #5 clock = ~clock;

  assign sp = load_cnt - pop_cnt;
  assign stack_empty = sp == 0;
  assign stack_top = sp > 0 ? mem[sp-1] : '0;
  assign stack_size = 3'(sp);

  always @(posedge clock) if (pop) pop_cnt <= pop_cnt + 1;

  always @(negedge clock) begin
    if (pop) begin
      tests++;
      if (stack_empty) begin
        fails++;
        $display("FAIL pop_on_empty: pop=1 with stack_empty=%0d, required pop=0", stack_empty);
      end
    end
    if (line_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_line_valid: line_value=%0d total=%0d, required no line_valid", line_value, total);
      end else begin
        exp_t e;
        e = q.pop_front();
        tests += 2;
        if (line_value !== e.v) begin
          fails++;
          $display("FAIL line_value: got %0d, required %0d", line_value, e.v);
        end
        if (total !== e.t) begin
          fails++;
          $display("FAIL total: got %0d, required %0d", total, e.t);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic load_stack(input int n, input int d[4]);
    for (int i = 0; i < n; i++) mem[i] = `DATA_WIDTH'(d[i]);
    load_cnt = pop_cnt + n;
  endtask

  task automatic wait_drained;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL line_timeout: %0d lines outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic run_line(input int n, input int d[4], input logic [63:0] v, input logic [63:0] t);
    load_stack(n, d);
    q.push_back('{v, t});
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_drained;
  endtask

  initial begin
    repeat (2) tick;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_pop", 64'(pop), 0);
    chk("rst_line_valid", 64'(line_valid), 0);
    chk("rst_line_value", line_value, 0);
    chk("rst_total", total, 0);
    reset = 1'b0;
    tick;
    run_line(4, '{9, 8, 7, 6}, 9876, 9876);
    chk("busy_after_line", 64'(busy), 0);
    chk("stack_drained", 64'(sp), 0);
    run_line(4, '{1, 2, 3, 4}, 1234, 11110);
    run_line(0, '{0, 0, 0, 0}, 0, 11110);
    load_stack(3, '{5, 0, 0, 0});
    q.push_back('{64'd500, 64'd11610});
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_drained;
    repeat (5) tick;
    chk("restart_ignored_busy", 64'(busy), 0);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("clear_total", total, 0);
    run_line(3, '{1, 0, 0, 0}, 100, 100);
    load_stack(2, '{5, 5, 0, 0});
    q.push_back('{64'd55, 64'd55});
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    wait_drained;
    load_stack(4, '{9, 9, 9, 9});
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_pop", 64'(pop), 0);
    chk("midrst_line_valid", 64'(line_valid), 0);
    chk("midrst_line_value", line_value, 0);
    chk("midrst_total", total, 0);
    load_cnt = pop_cnt;
    tick;
    reset = 1'b0;
    tick;
`ifdef STACK_DRAIN_CHECK_EN
    chk("err_after_reset", 64'(err), 0);
    run_line(3, '{1, 12, 3, 0}, 103, 103);
    chk("err_bad_digit", 64'(err), 1);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("err_cleared", 64'(err), 0);
`else
    run_line(3, '{1, 12, 3, 0}, 223, 223);
`endif
    chk("scoreboard_empty", 64'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stack_drain.md
Name: stack_drain

Overview:
- Reader/consumer end of `long_stack`: once a line's digits are fully pushed, it pops every stack entry and rebuilds the kept digits as a decimal number.
- Pop order is top-first, so the least-significant digit arrives first.
- Reports each line's value and keeps a running total across lines, giving the final AOC day-3 answer.
- Sits between `long_stack` and the top-level result register.

Parameters:
- MAX_CAP, 4, stack capacity; maximum digits per line.
- SUM_WIDTH, 64, width of line value, place value and running total. Must satisfy 10^MAX_CAP < 2^SUM_WIDTH.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: line complete, begin draining
- clear  in  1  synchronous clear of total
- stack_empty  in  1  stack has no entries
- stack_top  in  `DATA_WIDTH  current top entry (digit 0..9)
- stack_size  in  $clog2(MAX_CAP)+1  current stack occupancy
- pop  out  1  pop request; stack removes top on the clock edge when high
- busy  out  1  drain in progress
- line_value  out  SUM_WIDTH  value of the last completed line
- line_valid  out  1  one-cycle pulse; line_value and total are updated
- total  out  SUM_WIDTH  running sum of all line values

Behaviour:
- Reset (async, active-high):
  - state=IDLE; acc=0, place=1, total=0, line_value=0.
  - line_valid=0, pop=0, busy=0.
  - Reset during DRAIN abandons the line; the stack is not touched further.
- States:
  - IDLE: busy=0, pop=0. start=1 → DRAIN, with acc←0 and place←1.
  - DRAIN: busy=1, pop = !stack_empty (combinational).
    - On each edge with pop=1: acc←acc+stack_top×place; place←place×10, truncated to SUM_WIDTH.
    - On an edge with stack_empty=1: line_value←acc, total←total+acc, line_valid←1 for exactly one cycle; → IDLE.
- Latency: start sampled at edge E0; N entries popped at edges E1..EN; line_valid high in the cycle after edge EN+1.
  - Total start-to-valid is N+2 cycles.
- start is ignored while busy=1.
- start with an empty stack: one DRAIN cycle, then line_valid with line_value=0; total unchanged.
- stack_top is used modulo its low 4 bits only when the optional check is disabled (see below).
- total wraps modulo 2^SUM_WIDTH; no saturation.
- clear:
  - In any state: total←0 on the next edge.
  - When clear coincides with line completion: total←acc (clear first, then add). line_value and line_valid behave normally.
- stack_size is informational; it is used only by the optional check.
- pop must never be asserted while stack_empty=1.

Optional Feature:
- STACK_DRAIN_CHECK_EN defined:
  - Adds output err (1 bit), sticky until reset or clear.
  - err sets when a popped stack_top > 9; that entry contributes 0.
  - err also sets when the stack_size sampled at start exceeds MAX_CAP; the drain still completes.
- Undefined: no err port; stack_top[3:0] is used unchecked.

Decomposition:
- aoc_pkg holds:
  - state enum drain_state_t {IDLE, DRAIN}
  - localparam DIGIT_W=4
  - function pow10_fits(MAX_CAP, SUM_WIDTH), used for an elaboration-time assertion
- `DATA_WIDTH continues to come from common.svh.
- One sub-module, digit_mac: registered acc and place with a load/step interface. Handles the ×10 as (x<<3)+(x<<1).

Test Plan:
- Stack bottom→top 9,8,7,6; pulse start → pops on 4 consecutive edges; line_valid with line_value=9876, total=9876; busy low after.
- Second line 1,2,3,4 after the first → line_value=1234, total=11110.
- start with empty stack → exactly one line_valid, line_value=0, total unchanged; pop never asserted.
- start re-pulsed mid-drain → ignored; single line_valid only.
- clear on the same edge as completion of line 5,5 (total previously 100) → total=55. Assert reset mid-drain → all outputs 0 immediately, state IDLE.
- With STACK_DRAIN_CHECK_EN, stack 1,12,3 → err=1, line_value=103.
